// File: rtl/axi_lite_uart_regs.sv
`default_nettype none
// ============================================================================
// axi_lite_uart_regs : AXI4-Lite register bank (CTRL / TXD / RXD / STATUS)
// Rev 1.0
// ============================================================================
module axi_lite_uart_regs #(
   parameter int          C_S_AXI_ADDR_WIDTH = 32,
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter logic [31:0] CTRL_RESET         = 32'h0000_0000
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [31:0]                     CTRL_OUT,
   output logic [7:0]                      TX_DATA,
   output logic                            TX_VALID,
   input  logic                            TX_BUSY,
   input  logic [7:0]                      RX_DATA,
   input  logic                            RX_VALID,
   output logic                            RX_ACK,
   input  logic [15:0]                     STATUS_IN
);

   localparam logic [1:0] W_IDLE      = 2'd0;
   localparam logic [1:0] W_WAIT      = 2'd1;
   localparam logic [1:0] W_RESP      = 2'd2;
   localparam logic [0:0] R_IDLE      = 1'b0;
   localparam logic [0:0] R_DATA      = 1'b1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [1:0]  wstate_q, wstate_d;
   logic        aw_held_q, w_held_q, awready_q, wready_q;
   logic [1:0]  awidx_q, bresp_q;
   logic [31:0] wdata_q, ctrl_q;
   logic [3:0]  wstrb_q;
   logic [7:0]  tx_data_q;
   logic        tx_valid_q, err_q;
   logic [0:0]  rstate_q;
   logic        arready_q, rx_pend_q;
   logic [31:0] rdata_q, rd_mux_d;

   logic        aw_take, w_take, aw_have, w_have, commit, ar_take;
   logic [1:0]  widx, ridx;
   logic [31:0] wdata_sel;
   logic [3:0]  wstrb_sel;

   assign aw_take   = awready_q & S_AXI_AWVALID;
   assign w_take    = wready_q & S_AXI_WVALID;
   assign aw_have   = aw_held_q | aw_take;
   assign w_have    = w_held_q | w_take;
   // A channel completing its handshake this edge is used straight off the bus.
   assign widx      = aw_held_q ? awidx_q : S_AXI_AWADDR[3:2];
   assign wdata_sel = w_held_q ? wdata_q : S_AXI_WDATA;
   assign wstrb_sel = w_held_q ? wstrb_q : S_AXI_WSTRB;
   assign commit    = (wstate_q != W_RESP) & aw_have & w_have;
   assign ar_take   = arready_q & S_AXI_ARVALID;
   assign ridx      = S_AXI_ARADDR[3:2];

   always_comb begin
      wstate_d = wstate_q;
      if (wstate_q == W_RESP) begin
         if (S_AXI_BREADY) wstate_d = W_IDLE;
      end else if (commit) begin
         wstate_d = W_RESP;
      end else if (aw_have | w_have) begin
         wstate_d = W_WAIT;
      end else begin
         wstate_d = W_IDLE;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         wstate_q   <= W_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         awidx_q    <= 2'd0;
         wdata_q    <= 32'd0;
         wstrb_q    <= 4'd0;
         bresp_q    <= RESP_OKAY;
         ctrl_q     <= CTRL_RESET;
         tx_data_q  <= 8'd0;
         tx_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wstate_q   <= wstate_d;
         awready_q  <= S_AXI_AWVALID & ~aw_held_q & ~awready_q & (wstate_q != W_RESP);
         wready_q   <= S_AXI_WVALID & ~w_held_q & ~wready_q & (wstate_q != W_RESP);
         tx_valid_q <= 1'b0;
         if (aw_take) begin
            aw_held_q <= 1'b1;
            awidx_q   <= S_AXI_AWADDR[3:2];
         end
         if (w_take) begin
            w_held_q <= 1'b1;
            wdata_q  <= S_AXI_WDATA;
            wstrb_q  <= S_AXI_WSTRB;
         end
         if ((wstate_q == W_RESP) && S_AXI_BREADY) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
         end
         if (commit) begin
            bresp_q <= (widx == 2'd2) ? RESP_SLVERR : RESP_OKAY;
            case (widx)
               2'd0: begin
                  for (int b = 0; b < 4; b++)
                     if (wstrb_sel[b]) ctrl_q[8*b +: 8] <= wdata_sel[8*b +: 8];
               end
               2'd1: begin
                  if (wstrb_sel[0]) begin
                     tx_data_q  <= wdata_sel[7:0];
                     tx_valid_q <= 1'b1;
                  end
               end
               2'd2: err_q <= 1'b1;
               default: begin
                  if (wstrb_sel[1] && wdata_sel[8]) err_q <= 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      rd_mux_d = 32'd0;
      case (ridx)
         2'd0:    rd_mux_d = ctrl_q;
         2'd1:    rd_mux_d = {24'd0, tx_data_q};
         2'd2:    rd_mux_d = {24'd0, RX_DATA};
         default: rd_mux_d = {STATUS_IN, 7'd0, err_q, 6'd0, TX_BUSY, RX_VALID};
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rdata_q   <= 32'd0;
         rx_pend_q <= 1'b0;
      end else begin
         arready_q <= S_AXI_ARVALID & ~arready_q & (rstate_q == R_IDLE);
         if (ar_take) begin
            rstate_q  <= R_DATA;
            rdata_q   <= rd_mux_d;
            rx_pend_q <= (ridx == 2'd2) & RX_VALID;
         end else if ((rstate_q == R_DATA) && S_AXI_RREADY) begin
            rstate_q  <= R_IDLE;
            rx_pend_q <= 1'b0;
         end
      end
   end

   logic unused_addr_bits;
   assign unused_addr_bits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_AWADDR[1:0],
                               S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0]};

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = (wstate_q == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = (rstate_q == R_DATA);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RESP_OKAY;
   assign CTRL_OUT      = ctrl_q;
   assign TX_DATA       = tx_data_q;
   assign TX_VALID      = tx_valid_q;
   assign RX_ACK        = (rstate_q == R_DATA) & S_AXI_RREADY & rx_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_uart_regs.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_uart_regs : directed self-checking bench for axi_lite_uart_regs
// Rev 1.0
// ============================================================================
module tb_axi_lite_uart_regs;
   localparam logic [31:0] CTRL_RST = 32'hC0DE_0001;

   logic        clk = 1'b0, rstn = 1'b0;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, ctrl_out;
   logic [7:0]  tx_data;
   logic        tx_valid, rx_ack;
   logic        tx_busy = 1'b0, rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic [15:0] status_in = '0;

   int checks = 0, errors = 0;
   int tx_cnt = 0, ack_cnt = 0, wready_cnt = 0, awready_cnt = 0;

   axi_lite_uart_regs #(.C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .CTRL_RESET(CTRL_RST)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .CTRL_OUT(ctrl_out), .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_BUSY(tx_busy),
      .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_ACK(rx_ack), .STATUS_IN(status_in)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_valid) tx_cnt++;
      if (rx_ack) ack_cnt++;
      if (wready) wready_cnt++;
      if (awready) awready_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
      int n = 0;
      logic aw_hs, w_hs;
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      while ((awvalid || wvalid) && n < 20) begin
         aw_hs = awvalid & awready;
         w_hs  = wvalid & wready;
         step(); n++;
         if (aw_hs) awvalid = 1'b0;
         if (w_hs) wvalid = 1'b0;
      end
      while (!bvalid && n < 20) begin step(); n++; end
      if (!bvalid) begin
         checks++; errors++;
         $display("FAIL write_timeout addr=%h got bvalid=%b need 1", addr, bvalid);
         awvalid = 1'b0; wvalid = 1'b0; resp = 2'bxx;
         return;
      end
      resp = bresp;
      bready = 1'b1; step(); bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input int delay,
                          output logic [31:0] data, output logic stable);
      int n = 0;
      logic hs;
      stable = 1'b1;
      araddr = addr; arvalid = 1'b1;
      while (arvalid && n < 20) begin
         hs = arready;
         step(); n++;
         if (hs) arvalid = 1'b0;
      end
      while (!rvalid && n < 20) begin step(); n++; end
      if (!rvalid) begin
         checks++; errors++;
         $display("FAIL read_timeout addr=%h got rvalid=%b need 1", addr, rvalid);
         arvalid = 1'b0; data = 'x;
         return;
      end
      data = rdata;
      for (int i = 0; i < delay; i++) begin
         step();
         if (!rvalid || rdata !== data) stable = 1'b0;
      end
      rready = 1'b1; step(); rready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) step();
      checks++;
      if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
         errors++; $display("FAIL reset_handshake got %b need 00000", {awready, wready, bvalid, arready, rvalid});
      end
      checks++;
      if ({bresp, rresp, rdata} !== 36'd0) begin
         errors++; $display("FAIL reset_resp_data got %h need 0", {bresp, rresp, rdata});
      end
      checks++;
      if (ctrl_out !== CTRL_RST) begin
         errors++; $display("FAIL reset_ctrl got %h need %h", ctrl_out, CTRL_RST);
      end
      checks++;
      if ({tx_data, tx_valid, rx_ack} !== 10'd0) begin
         errors++; $display("FAIL reset_tx_rx got %h need 0", {tx_data, tx_valid, rx_ack});
      end
      rstn = 1'b1;
      step();
   endtask

   task automatic test_ctrl();
      logic [1:0] r;
      logic [31:0] d;
      logic s;
      awaddr = 32'h0; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      step();
      checks++;
      if ({awready, wready, bvalid} !== 3'b110) begin
         errors++; $display("FAIL ctrl_ready_cycle1 got %b need 110", {awready, wready, bvalid});
      end
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      checks++;
      if ({bvalid, bresp, ctrl_out} !== {1'b1, 2'b00, 32'h1234_5678}) begin
         errors++; $display("FAIL ctrl_commit_cycle2 got %b/%b/%h need 1/00/12345678", bvalid, bresp, ctrl_out);
      end
      bready = 1'b1; step(); bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0) begin
         errors++; $display("FAIL ctrl_bvalid_clear got %b need 0", bvalid);
      end
      do_write(32'h0, 32'h0000_00AA, 4'b0001, r);
      do_read(32'h0, 0, d, s);
      checks++;
      if ({r, d} !== {2'b00, 32'h1234_56AA}) begin
         errors++; $display("FAIL ctrl_lane0 got %b/%h need 00/123456aa", r, d);
      end
      do_write(32'hFFFF_FF03, 32'h00FF_0000, 4'b0100, r);
      do_read(32'h0000_00F0, 0, d, s);
      checks++;
      if (d !== 32'h12FF_56AA) begin
         errors++; $display("FAIL ctrl_alias_lane2 got %h need 12ff56aa", d);
      end
   endtask

   task automatic test_txd();
      logic [1:0] r;
      logic [31:0] d;
      logic s;
      int t0;
      t0 = tx_cnt;
      do_write(32'h4, 32'hFFFF_FF41, 4'b0001, r);
      checks++;
      if ({r, tx_cnt - t0, tx_data} !== {2'b00, 32'd1, 8'h41}) begin
         errors++; $display("FAIL txd_write got resp=%b pulses=%0d data=%h need 00/1/41", r, tx_cnt - t0, tx_data);
      end
      do_read(32'h4, 0, d, s);
      checks++;
      if (d !== 32'h0000_0041) begin
         errors++; $display("FAIL txd_read got %h need 00000041", d);
      end
      t0 = tx_cnt;
      do_write(32'h4, 32'h0000_0099, 4'b0010, r);
      checks++;
      if ({r, tx_cnt - t0, tx_data} !== {2'b00, 32'd0, 8'h41}) begin
         errors++; $display("FAIL txd_nostrb got resp=%b pulses=%0d data=%h need 00/0/41", r, tx_cnt - t0, tx_data);
      end
   endtask

   task automatic test_rxd();
      logic [31:0] d;
      logic s;
      int a0;
      rx_valid = 1'b1; rx_data = 8'h5A;
      a0 = ack_cnt;
      do_read(32'h8, 3, d, s);
      checks++;
      if ({d, s, ack_cnt - a0} !== {32'h0000_005A, 1'b1, 32'd1}) begin
         errors++; $display("FAIL rxd_valid got data=%h stable=%b acks=%0d need 5a/1/1", d, s, ack_cnt - a0);
      end
      rx_valid = 1'b0; rx_data = 8'h33;
      a0 = ack_cnt;
      do_read(32'h8, 1, d, s);
      checks++;
      if ({d, ack_cnt - a0} !== {32'h0000_0033, 32'd0}) begin
         errors++; $display("FAIL rxd_empty got data=%h acks=%0d need 33/0", d, ack_cnt - a0);
      end
   endtask

   task automatic test_status_err();
      logic [1:0] r;
      logic [31:0] d;
      logic s;
      status_in = 16'hBEEF; tx_busy = 1'b1; rx_valid = 1'b1;
      do_read(32'hC, 0, d, s);
      checks++;
      if (d !== 32'hBEEF_0003) begin
         errors++; $display("FAIL status_live got %h need beef0003", d);
      end
      do_write(32'h8, 32'h0000_00FF, 4'hF, r);
      do_read(32'hC, 0, d, s);
      checks++;
      if ({r, d} !== {2'b10, 32'hBEEF_0103}) begin
         errors++; $display("FAIL status_err_set got %b/%h need 10/beef0103", r, d);
      end
      do_write(32'hC, 32'h0000_0100, 4'b0001, r);
      do_read(32'hC, 0, d, s);
      checks++;
      if ({r, d} !== {2'b00, 32'hBEEF_0103}) begin
         errors++; $display("FAIL status_clear_wrong_lane got %b/%h need 00/beef0103", r, d);
      end
      do_write(32'hC, 32'h0000_0100, 4'b0010, r);
      do_read(32'hC, 0, d, s);
      checks++;
      if ({r, d} !== {2'b00, 32'hBEEF_0003}) begin
         errors++; $display("FAIL status_err_clear got %b/%h need 00/beef0003", r, d);
      end
      tx_busy = 1'b0; rx_valid = 1'b0;
   endtask

   task automatic test_w_before_aw();
      int w0, a0;
      logic held;
      w0 = wready_cnt; a0 = awready_cnt;
      wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1; awaddr = 32'h0;
      repeat (4) step();
      checks++;
      if ({awready, bvalid, ctrl_out} !== {1'b0, 1'b0, 32'h12FF_56AA}) begin
         errors++; $display("FAIL wfirst_waiting got %b/%b/%h need 0/0/12ff56aa", awready, bvalid, ctrl_out);
      end
      awvalid = 1'b1;
      step();
      checks++;
      if ({awready, bvalid} !== 2'b10) begin
         errors++; $display("FAIL wfirst_awready got %b need 10", {awready, bvalid});
      end
      step();
      awvalid = 1'b0;
      held = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (!bvalid || bresp !== 2'b00) held = 1'b0;
         step();
      end
      checks++;
      if ({held, bvalid, ctrl_out} !== {1'b1, 1'b1, 32'h0BAD_F00D}) begin
         errors++; $display("FAIL wfirst_bhold got held=%b bvalid=%b ctrl=%h need 1/1/0badf00d", held, bvalid, ctrl_out);
      end
      bready = 1'b1; step(); bready = 1'b0;
      wvalid = 1'b0;
      step();
      checks++;
      if ({bvalid, wready_cnt - w0, awready_cnt - a0} !== {1'b0, 32'd1, 32'd1}) begin
         errors++; $display("FAIL wfirst_single got bvalid=%b wready=%0d awready=%0d need 0/1/1",
                            bvalid, wready_cnt - w0, awready_cnt - a0);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] r;
      logic [31:0] d;
      logic s;
      awaddr = 32'h0; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 32'h0; arvalid = 1'b1;
      step();
      step();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      checks++;
      if ({rvalid, rdata, bvalid, ctrl_out} !== {1'b1, 32'h0BAD_F00D, 1'b1, 32'h1111_2222}) begin
         errors++; $display("FAIL same_cycle got r=%b %h b=%b ctrl=%h need 1 0badf00d 1 11112222",
                            rvalid, rdata, bvalid, ctrl_out);
      end
      bready = 1'b1; rready = 1'b1; step(); bready = 1'b0; rready = 1'b0;
      do_write(32'h0, 32'hA5A5_0000, 4'b1100, r);
      do_write(32'h0, 32'h0000_5A5A, 4'b0011, r);
      do_read(32'h0, 0, d, s);
      checks++;
      if ({r, d} !== {2'b00, 32'hA5A5_5A5A}) begin
         errors++; $display("FAIL back_to_back got %b/%h need 00/a5a55a5a", r, d);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] r;
      logic [31:0] d;
      logic s;
      awaddr = 32'h0; wdata = 32'h0000_0055; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 32'h4; arvalid = 1'b1;
      step();
      step();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      checks++;
      if ({bvalid, rvalid, tx_data} !== {1'b1, 1'b1, 8'h41}) begin
         errors++; $display("FAIL midreset_pending got %b/%b/%h need 1/1/41", bvalid, rvalid, tx_data);
      end
      rstn = 1'b0;
      step();
      checks++;
      if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, ctrl_out, tx_data, tx_valid, rx_ack}
          !== {5'b0, 4'b0, 32'd0, CTRL_RST, 8'd0, 2'b0}) begin
         errors++; $display("FAIL midreset_outputs got bv=%b rv=%b rdata=%h ctrl=%h tx=%h need 0/0/0/%h/0",
                            bvalid, rvalid, rdata, ctrl_out, tx_data, CTRL_RST);
      end
      rstn = 1'b1;
      step();
      do_write(32'h0, 32'h600D_CAFE, 4'hF, r);
      do_read(32'h0, 0, d, s);
      checks++;
      if ({r, d, ctrl_out} !== {2'b00, 32'h600D_CAFE, 32'h600D_CAFE}) begin
         errors++; $display("FAIL midreset_recover got %b/%h/%h need 00/600dcafe/600dcafe", r, d, ctrl_out);
      end
   endtask

   initial begin
      step();
      test_reset();
      test_ctrl();
      test_txd();
      test_rxd();
      test_status_err();
      test_w_before_aw();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_lite_uart_regs.md
Name: axi_lite_uart_regs

Overview:
- AXI4-Lite slave register bank. It is the responder end of the UART-bridge AXI master, which issues single byte-wide writes and reads at 4-bit addresses.
- Exposes one control register, a TX byte strobe, an RX byte pop and a status word to the camera/UART datapath.
- One outstanding write and one outstanding read at a time. Read and write channels operate independently.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32: AXI address width. Only bits [3:2] are decoded; all other bits are ignored.
- C_S_AXI_DATA_WIDTH, 32: AXI data width. Fixed at 32; any other value is unsupported.
- CTRL_RESET, 32'h0000_0000: reset value of the CTRL register.

Ports:
- S_AXI_ACLK in 1: clock, all logic on the rising edge.
- S_AXI_ARESETN in 1: reset; synchronous and active-low.
- S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH: write address.
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write address handshake.
- S_AXI_WDATA in 32 / S_AXI_WSTRB in 4: write data and byte strobes.
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write data handshake.
- S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write response.
- S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH / S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read address.
- S_AXI_RDATA out 32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1: read data.
- CTRL_OUT out 32: current CTRL register value.
- TX_DATA out 8: last byte written to the TXD register.
- TX_VALID out 1: one-cycle pulse when a new TX byte is committed.
- TX_BUSY in 1: live transmitter busy flag.
- RX_DATA in 8 / RX_VALID in 1: head of the receive queue.
- RX_ACK out 1: one-cycle pop pulse.
- STATUS_IN in 16: user status, mapped to STATUS[31:16].

Behaviour:
- Register map (word index = addr[3:2]):
  - 0 CTRL: RW, byte-lane masked by WSTRB.
  - 1 TXD: RW. Bits [7:0] hold the byte; [31:8] read as 0.
  - 2 RXD: RO. Reads return {24'b0, RX_DATA}. Writes are rejected with SLVERR, and no register changes.
  - 3 STATUS: RO except bit 8.
    - [0] = RX_VALID (live), [1] = TX_BUSY (live).
    - [8] = ERR sticky. Set by any SLVERR write; cleared by writing 1 to bit 8 with WSTRB[1]=1.
    - [31:16] = STATUS_IN. All other bits read 0.
- Reset: all READY/VALID outputs 0, BRESP=RRESP=2'b00, RDATA=0, CTRL_OUT=CTRL_RESET, TX_DATA=0, TX_VALID=0, RX_ACK=0, ERR=0. Reset mid-transaction discards every held address, data and response.
- Write path states: W_IDLE, W_WAIT (one of AW/W held), W_RESP.
  - AWREADY pulses for 1 cycle on the edge after AWVALID is seen high, provided no address is held and BVALID=0. WREADY follows the same rule for W.
  - AW and W may arrive in either order or together. Each is latched at its own handshake.
  - The commit happens on the edge after both are held. At that edge the register updates, BVALID rises and BRESP is set.
  - With AW and W presented in cycle 0: READY in cycle 1, BVALID in cycle 2.
  - BVALID and BRESP hold until BREADY=1. Held state clears at the B handshake.
  - No new AW or W is accepted while BVALID=1.
- TX_VALID pulses in the commit cycle only for a TXD write with WSTRB[0]=1; TX_DATA updates at the same edge. A TXD write with WSTRB[0]=0 returns OKAY, with no pulse and no change.
- Read path states: R_IDLE, R_DATA.
  - ARREADY pulses for 1 cycle on the edge after ARVALID is seen high while RVALID=0.
  - On the next edge RDATA is captured from the register values at that edge, RVALID=1 and RRESP=OKAY (reads never error).
  - With ARVALID in cycle 0: ARREADY in cycle 1, RVALID in cycle 2.
  - RDATA/RVALID hold until RREADY=1.
- RX_ACK pulses for 1 cycle at the R handshake of an RXD read, only if RX_VALID was 1 when RDATA was captured. Reading RXD with RX_VALID=0 returns the RX_DATA value, with no ACK.
- Simultaneous write commit and read capture of the same register: the read returns the pre-commit value.
- An ERR set and a W1C clear in the same cycle: the set wins.
- Unaligned addresses use [3:2] only. Upper address bits alias.

Test Plan:
- Write CTRL 0x12345678 with WSTRB=4'hF, then WSTRB=4'b0001 with data 0xAA -> read CTRL = 0x123456AA. BRESP=00. CTRL_OUT matches 2 cycles after AW/W.
- Write TXD 0x41, WSTRB=0001 -> TX_VALID high exactly 1 cycle with TX_DATA=0x41. Read TXD = 0x00000041.
- RX_VALID=1, RX_DATA=0x5A; read 0x8 with RREADY delayed 3 cycles -> RDATA=0x0000005A held; single RX_ACK pulse at the handshake. Repeat with RX_VALID=0 -> no ACK.
- Write 0x8 -> BRESP=2'b10 and STATUS[8]=1. Write 0xC with data 0x100, WSTRB=0010 -> STATUS[8]=0.
- W presented 4 cycles before AW; BREADY held low 5 cycles -> single commit, BVALID stable until BREADY, no second WREADY meanwhile.
- Assert reset while BVALID=1 and RVALID=1 -> all outputs at reset values next edge. A subsequent write completes normally.
